stack_control_unit: RTL

- Control unit (UC) that sits directly upstream of the stack datapath.
- Fetches instructions from a synchronous instruction ROM, decodes them and sequences the datapath control levels and strobes: wren, controle_pilha, clk_pilha, clk_temp1/2, load_temp1/2, din_UC and opcode.
- Tracks stack depth, detects underflow and overflow, and resolves the conditional branches If_eq, If_gt, If_lt, If_ge and If_le from the ULA compare flag.

---
 rtl/stack_control_unit_if.sv | 33 +++
 rtl/stack_control_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stack_control_unit_if.sv
// stack_control_unit_if: bundle between the control unit, instruction ROM, ULA and stack datapath
interface stack_control_unit_if #(
  parameter int PC_W    = 8,
  parameter int DEPTH_W = 5
);
  logic               start;
  logic               cond_true;
  logic [20:0]        instr;
  logic [PC_W-1:0]    pc;
  logic [15:0]        din_UC;
  logic [4:0]         opcode;
  logic               wren;
  logic               controle_pilha;
  logic               clk_pilha;
  logic               clk_temp1;
  logic               clk_temp2;
  logic               load_temp1;
  logic               load_temp2;
  logic               busy;
  logic               halted;
  logic               error;
  logic [DEPTH_W-1:0] depth;
  modport master (
    input  start, cond_true, instr,
    output pc, din_UC, opcode, wren, controle_pilha, clk_pilha, clk_temp1, clk_temp2,
           load_temp1, load_temp2, busy, halted, error, depth
  );
  modport slave (
    output start, cond_true, instr,
    input  pc, din_UC, opcode, wren, controle_pilha, clk_pilha, clk_temp1, clk_temp2,
           load_temp1, load_temp2, busy, halted, error, depth
  );
endinterface

// File: rtl/stack_control_unit.sv
// stack_control_unit: fetches/decodes ROM instructions and sequences the stack datapath strobes
module stack_control_unit #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = 5
) (
  input logic clk,
  input logic reset,
  stack_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, POPA, LATA, SETB, POPB, LATB, SETX, EXEC, CMP, PUSH, POPS, HALT
  } state_t;
  localparam logic [4:0] OP_PUSH = 5'd1, OP_POP = 5'd2, OP_ADD = 5'd3, OP_CMP = 5'd11;
  localparam logic [4:0] OP_NOT = 5'd12, OP_IF_EQ = 5'd13, OP_IF_LE = 5'd17;
  localparam logic [4:0] OP_GOTO = 5'd18, OP_HALT = 5'd19;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(STACK_DEPTH);
  state_t state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [15:0] din_n;
  logic [4:0] op_n, dop;
  logic [DEPTH_W-1:0] depth_n, need;
  logic wren_n, ctl_n, cp_n, ct1_n, ct2_n, lt1_n, lt2_n, err_n;
  logic dec_bin, dec_if, cur_if, ok;
  always_comb begin
    dop = bus.instr[20:16];
    dec_bin = dop >= OP_ADD && dop <= OP_CMP;
    dec_if = dop >= OP_IF_EQ && dop <= OP_IF_LE;
    cur_if = bus.opcode >= OP_IF_EQ && bus.opcode <= OP_IF_LE;
    need = (dop == OP_POP || dop == OP_NOT) ? DEPTH_W'(1) : (dec_bin || dec_if) ? DEPTH_W'(2) : '0;
    ok = dop == OP_PUSH ? bus.depth < MAX_D : bus.depth >= need;
  end
  // Levels are registered on leaving a state so they sit one cycle ahead of the strobe that uses them
  always_comb begin
    state_n = state;
    pc_n = bus.pc;
    din_n = bus.din_UC;
    op_n = bus.opcode;
    wren_n = bus.wren;
    ctl_n = bus.controle_pilha;
    lt1_n = bus.load_temp1;
    lt2_n = bus.load_temp2;
    cp_n = 1'b0;
    ct1_n = 1'b0;
    ct2_n = 1'b0;
    err_n = bus.error;
    depth_n = bus.depth;
    case (state)
      IDLE, HALT: if (bus.start) begin
        pc_n = '0;
        err_n = 1'b0;
        state_n = FETCH;
      end
      FETCH: state_n = DECODE;
      DECODE: begin
        op_n = dop;
        din_n = bus.instr[15:0];
        wren_n = 1'b0;
        ctl_n = 1'b0;
        lt1_n = 1'b0;
        lt2_n = 1'b0;
        if (!ok) begin
          err_n = 1'b1;
          state_n = HALT;
        end else if (dop == OP_PUSH) begin
          wren_n = 1'b1;
          state_n = PUSH;
        end else if (dop == OP_POP) state_n = POPS;
        else if (dec_bin || dec_if || dop == OP_NOT) begin
          lt1_n = 1'b1;
          state_n = POPA;
        end else if (dop == OP_GOTO) begin
          pc_n = bus.instr[PC_W-1:0];
          state_n = FETCH;
        end else if (dop == OP_HALT) state_n = HALT;
        else begin
          pc_n = bus.pc + 1'b1;
          state_n = FETCH;
        end
      end
      POPA: begin
        cp_n = 1'b1;
        depth_n = bus.depth - 1'b1;
        state_n = LATA;
      end
      LATA: begin
        ct1_n = 1'b1;
        state_n = bus.opcode == OP_NOT ? SETX : SETB;
      end
      SETB: begin
        lt1_n = 1'b0;
        lt2_n = 1'b1;
        state_n = POPB;
      end
      POPB: begin
        cp_n = 1'b1;
        depth_n = bus.depth - 1'b1;
        state_n = LATB;
      end
      LATB: begin
        ct2_n = 1'b1;
        state_n = cur_if ? CMP : SETX;
      end
      SETX: begin
        lt1_n = 1'b0;
        lt2_n = 1'b0;
        wren_n = 1'b1;
        ctl_n = 1'b1;
        state_n = EXEC;
      end
      EXEC, PUSH: begin
        cp_n = 1'b1;
        depth_n = bus.depth + 1'b1;
        pc_n = bus.pc + 1'b1;
        state_n = FETCH;
      end
      POPS: begin
        cp_n = 1'b1;
        depth_n = bus.depth - 1'b1;
        pc_n = bus.pc + 1'b1;
        state_n = FETCH;
      end
      CMP: begin
        pc_n = bus.cond_true ? bus.din_UC[PC_W-1:0] : bus.pc + 1'b1;
        state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bus.pc <= '0;
      bus.din_UC <= '0;
      bus.opcode <= '0;
      bus.wren <= 1'b0;
      bus.controle_pilha <= 1'b0;
      bus.clk_pilha <= 1'b0;
      bus.clk_temp1 <= 1'b0;
      bus.clk_temp2 <= 1'b0;
      bus.load_temp1 <= 1'b0;
      bus.load_temp2 <= 1'b0;
      bus.busy <= 1'b0;
      bus.halted <= 1'b0;
      bus.error <= 1'b0;
      bus.depth <= '0;
    end else begin
      state <= state_n;
      bus.pc <= pc_n;
      bus.din_UC <= din_n;
      bus.opcode <= op_n;
      bus.wren <= wren_n;
      bus.controle_pilha <= ctl_n;
      bus.clk_pilha <= cp_n;
      bus.clk_temp1 <= ct1_n;
      bus.clk_temp2 <= ct2_n;
      bus.load_temp1 <= lt1_n;
      bus.load_temp2 <= lt2_n;
      bus.busy <= !(state_n == IDLE || state_n == HALT);
      bus.halted <= state_n == HALT;
      bus.error <= err_n;
      bus.depth <= depth_n;
    end
  end
endmodule
